// File: rtl/wait_state_memory_responder_if.sv
// Processor memory bus between an initiator (master) and a memory responder (slave).
interface wait_state_memory_responder_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        abort;
    logic        write;
    logic        size;
    logic [1:0]  prot;
    logic [1:0]  trans;
    logic        n_wait;

    modport master (
        output addr, wdata, write, size, prot, trans,
        input  rdata, abort, n_wait
    );

    modport slave (
        input  addr, wdata, write, size, prot, trans,
        output rdata, abort, n_wait
    );
endinterface

// File: rtl/wait_state_memory_responder.sv
// Memory responder with programmable N/S wait states, byte/word sizing and
// abort generation for alignment, range and protection faults.
// INIT_FILE names the hex image used by the implementation flow to preload
// the word array; the array itself is never cleared by reset.
module wait_state_memory_responder #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned WAIT_N    = 1,
    parameter int unsigned WAIT_S    = 0,
    parameter logic [31:0] PROT_BASE = 32'h0000_0100,
    parameter              INIT_FILE = ""
) (
    input  logic                           clk,
    input  logic                           n_reset,
    wait_state_memory_responder_if.slave   bus
);
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_N_C = WAIT_N[3:0];
    localparam logic [3:0]  WAIT_S_C = WAIT_S[3:0];

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        n_wait_q, n_wait_d;
    logic [31:0] rdata_q;
    logic        abort_q;

    // Request captured at acceptance, replayed when the wait count expires
    logic [31:0] addr_q, wdata_q;
    logic        write_q, size_q, priv_q;

    logic [31:0] mem [DEPTH];

    logic        latch_en;
    logic        exec;
    logic [3:0]  wait_sel;
    logic [31:0] req_addr, req_wdata;
    logic        req_write, req_size, req_priv;
    logic [ADDR_W-1:0] req_idx;
    logic        fault_align, fault_range, fault_prot, fault;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wd;
    logic        prot_unused;

    // prot[0] distinguishes opcode/data fetches, which this memory treats alike
    assign prot_unused = bus.prot[0];

    // State, wait counter and n_wait register
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            n_wait_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_wait_q <= n_wait_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, execute on expiry
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_wait_d = n_wait_q;
        latch_en = 1'b0;
        exec     = 1'b0;
        wait_sel = (bus.trans == 2'b11) ? WAIT_S_C : WAIT_N_C;
        case (state_q)
            ST_IDLE: begin
                if (bus.trans[1]) begin
                    latch_en = 1'b1;
                    if (wait_sel == 4'd0) begin
                        exec = 1'b1;
                    end else begin
                        state_d  = ST_WAIT;
                        cnt_d    = wait_sel;
                        n_wait_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    exec     = 1'b1;
                    state_d  = ST_IDLE;
                    n_wait_d = 1'b1;
                    cnt_d    = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the request fields at acceptance
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            size_q  <= 1'b0;
            priv_q  <= 1'b0;
        end else if (latch_en) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            write_q <= bus.write;
            size_q  <= bus.size;
            priv_q  <= bus.prot[1];
        end
    end

    // Zero-wait accesses use the live bus; delayed ones use the captured copy
    always_comb begin
        req_addr  = addr_q;
        req_wdata = wdata_q;
        req_write = write_q;
        req_size  = size_q;
        req_priv  = priv_q;
        if (state_q == ST_IDLE) begin
            req_addr  = bus.addr;
            req_wdata = bus.wdata;
            req_write = bus.write;
            req_size  = bus.size;
            req_priv  = bus.prot[1];
        end
    end

    assign req_idx     = req_addr[ADDR_W+1:2];
    assign fault_align = req_size & (req_addr[1:0] != 2'b00);
    assign fault_range = (req_addr >> (ADDR_W + 2)) != 32'd0;
    assign fault_prot  = req_write & (req_addr < PROT_BASE) & ~req_priv;
    assign fault       = fault_align | fault_range | fault_prot;

    // Reset must suppress any write that would otherwise fire on this edge
    assign mem_we = exec & req_write & ~fault & n_reset;

    // Per-lane enables and data: a byte write lands wdata[7:0] on its lane
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_be[gi] = req_size | (req_addr[1:0] == 2'(gi));
            assign mem_wd[8*gi +: 8] = req_size ? req_wdata[8*gi +: 8] : req_wdata[7:0];
        end
    endgenerate

    // Byte-enabled array write
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[req_idx][8*i +: 8] <= mem_wd[8*i +: 8];
                end
            end
        end
    end

    // Registered read with byte replication; writes leave rdata untouched
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rdata_q <= '0;
        end else if (exec && !req_write) begin
            if (fault) begin
                rdata_q <= '0;
            end else if (req_size) begin
                rdata_q <= mem[req_idx];
            end else begin
                rdata_q <= {4{mem[req_idx][8*req_addr[1:0] +: 8]}};
            end
        end
    end

    // abort pulses only in the cycle following a faulting execution
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= exec & fault;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.abort  = abort_q;
    assign bus.n_wait = n_wait_q;
endmodule

// File: tb/tb_wait_state_memory_responder.sv
// Self-checking bench: table of bus transactions on a WAIT_N=1/WAIT_S=0
// responder, plus hand sequences for reset, coherent cycles, abort width and
// reset during a wait on a WAIT_N=3 responder.
module tb_wait_state_memory_responder;
    logic clk = 1'b0;
    logic n_reset_a;
    logic n_reset_b;

    wait_state_memory_responder_if bus_a ();
    wait_state_memory_responder_if bus_b ();

    wait_state_memory_responder #(
        .ADDR_W(13), .WAIT_N(1), .WAIT_S(0), .PROT_BASE(32'h0000_0100), .INIT_FILE("")
    ) dut_a (
        .clk(clk), .n_reset(n_reset_a), .bus(bus_a)
    );

    wait_state_memory_responder #(
        .ADDR_W(13), .WAIT_N(3), .WAIT_S(0), .PROT_BASE(32'h0000_0100), .INIT_FILE("")
    ) dut_b (
        .clk(clk), .n_reset(n_reset_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        sz;
        logic [1:0]  pr;
        logic [1:0]  tr;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        ab;
        int          w;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        ab;
        int          w;
    } exp_t;

    exp_t sb [$];
    vec_t vecs [22];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic wr, input logic sz, input logic [1:0] pr,
                         input logic [1:0] tr, input logic [31:0] ad, input logic [31:0] wd);
        if (d == 0) begin
            bus_a.write = wr; bus_a.size = sz; bus_a.prot = pr;
            bus_a.trans = tr; bus_a.addr = ad; bus_a.wdata = wd;
        end else begin
            bus_b.write = wr; bus_b.size = sz; bus_b.prot = pr;
            bus_b.trans = tr; bus_b.addr = ad; bus_b.wdata = wd;
        end
    endtask

    task automatic sample(input int d, output logic [31:0] rd, output logic ab, output logic nw);
        if (d == 0) begin
            rd = bus_a.rdata; ab = bus_a.abort; nw = bus_a.n_wait;
        end else begin
            rd = bus_b.rdata; ab = bus_b.abort; nw = bus_b.n_wait;
        end
    endtask

    task automatic set_idle(input int d);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    endtask

    // One bus transaction: drive, wait out n_wait (bounded), compare against scoreboard
    task automatic access(input int d, input vec_t v, input string nm);
        exp_t        e;
        int          waits;
        bit          done;
        logic [31:0] rd;
        logic        ab;
        logic        nw;
        @(negedge clk);
        drive(d, v.wr, v.sz, v.pr, v.tr, v.ad, v.wd);
        sb.push_back('{v.rd, v.ab, v.w});
        waits = 0;
        done  = 1'b0;
        rd    = '0;
        ab    = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            sample(d, rd, ab, nw);
            if (nw) begin
                done = 1'b1;
            end else begin
                waits++;
                @(posedge clk);
            end
        end
        e = sb.pop_front();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: n_wait stayed low for %0d cycles, required %0d", nm, waits, e.w);
        end else begin
            check({nm, " wait"}, 32'(waits), 32'(e.w));
            check({nm, " abort"}, {31'd0, ab}, {31'd0, e.ab});
            check({nm, " rdata"}, rd, e.rd);
            $display("txn %s: wr=%0b sz=%0b prot=%b trans=%b addr=%h wdata=%h -> rdata=%h abort=%0b waits=%0d",
                     nm, v.wr, v.sz, v.pr, v.tr, v.ad, v.wd, rd, ab, waits);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        ab;
        logic        nw;
        vec_t        v;

        // wr sz prot trans addr wdata | exp rdata abort waits
        vecs[0]  = '{1'b1, 1'b1, 2'b10, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1};
        vecs[1]  = '{1'b1, 1'b1, 2'b10, 2'b11, 32'h0000_0014, 32'h0123_4567, 32'h0000_0000, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b1, 2'b10, 2'b10, 32'h0000_0200, 32'h1122_3344, 32'h0000_0000, 1'b0, 1};
        vecs[3]  = '{1'b1, 1'b1, 2'b10, 2'b10, 32'h0000_0080, 32'h0BAD_C0DE, 32'h0000_0000, 1'b0, 1};
        vecs[4]  = '{1'b0, 1'b1, 2'b00, 2'b10, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 2'b11, 32'h0000_0014, 32'h0000_0000, 32'h0123_4567, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b0, 2'b10, 2'b10, 32'h0000_0203, 32'h1234_56A5, 32'h0123_4567, 1'b0, 1};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 2'b10, 32'h0000_0200, 32'h0000_0000, 32'hA522_3344, 1'b0, 1};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 2'b10, 32'h0000_0201, 32'h0000_0000, 32'h3333_3333, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 2'b11, 32'h0000_0203, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 0};
        vecs[10] = '{1'b1, 1'b1, 2'b00, 2'b10, 32'h0000_0080, 32'hCAFE_F00D, 32'hA5A5_A5A5, 1'b1, 1};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 2'b10, 32'h0000_0080, 32'h0000_0000, 32'h0BAD_C0DE, 1'b0, 1};
        vecs[12] = '{1'b1, 1'b1, 2'b10, 2'b10, 32'h0000_0080, 32'hCAFE_F00D, 32'h0BAD_C0DE, 1'b0, 1};
        vecs[13] = '{1'b0, 1'b1, 2'b00, 2'b11, 32'h0000_0080, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 0};
        vecs[14] = '{1'b0, 1'b1, 2'b00, 2'b10, 32'h0000_0102, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[15] = '{1'b0, 1'b1, 2'b00, 2'b11, 32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 1'b1, 0};
        vecs[16] = '{1'b0, 1'b0, 2'b00, 2'b10, 32'h0000_8003, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[17] = '{1'b1, 1'b0, 2'b00, 2'b11, 32'h0000_00FF, 32'h0000_00AA, 32'h0000_0000, 1'b1, 0};
        vecs[18] = '{1'b1, 1'b1, 2'b00, 2'b10, 32'h0000_0100, 32'h600D_F00D, 32'h0000_0000, 1'b0, 1};
        vecs[19] = '{1'b0, 1'b1, 2'b00, 2'b11, 32'h0000_0100, 32'h0000_0000, 32'h600D_F00D, 1'b0, 0};
        vecs[20] = '{1'b0, 1'b0, 2'b00, 2'b10, 32'h0000_0010, 32'h0000_0000, 32'hEFEF_EFEF, 1'b0, 1};
        vecs[21] = '{1'b0, 1'b0, 2'b10, 2'b11, 32'h0000_0012, 32'h0000_0000, 32'hADAD_ADAD, 1'b0, 0};

        // Reset held for two edges with a request pending on the bus
        n_reset_a = 1'b0;
        n_reset_b = 1'b0;
        drive(0, 1'b1, 1'b1, 2'b10, 2'b10, 32'h0000_0010, 32'hFFFF_FFFF);
        drive(1, 1'b1, 1'b1, 2'b10, 2'b10, 32'h0000_0040, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        sample(0, rd, ab, nw);
        check("reset a n_wait", {31'd0, nw}, 32'd1);
        check("reset a abort", {31'd0, ab}, 32'd0);
        check("reset a rdata", rd, 32'h0);
        sample(1, rd, ab, nw);
        check("reset b n_wait", {31'd0, nw}, 32'd1);
        check("reset b abort", {31'd0, ab}, 32'd0);
        check("reset b rdata", rd, 32'h0);
        @(negedge clk);
        n_reset_a = 1'b1;
        n_reset_b = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);

        // Table of back-to-back transactions on responder A
        for (int i = 0; i < 22; i++) begin
            access(0, vecs[i], $sformatf("vec%0d", i));
        end

        // abort is a single-cycle pulse: fault, then one idle cycle
        v = '{1'b0, 1'b1, 2'b00, 2'b10, 32'h0000_0102, 32'h0, 32'h0, 1'b1, 1};
        access(0, v, "abort_pulse");
        set_idle(0);
        @(posedge clk);
        #1;
        sample(0, rd, ab, nw);
        check("abort after pulse", {31'd0, ab}, 32'd0);
        check("rdata after pulse", rd, 32'h0);

        // Coherent cycles perform no access and never stall
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'b10, 2'b01, 32'h0000_0010, 32'h0000_0000);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            sample(0, rd, ab, nw);
            check($sformatf("coherent n_wait %0d", k), {31'd0, nw}, 32'd1);
        end
        v = '{1'b0, 1'b1, 2'b00, 2'b10, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1};
        access(0, v, "after_coherent");
        set_idle(0);

        // Responder B (WAIT_N=3): seed 0x40, then reset in the 2nd wait cycle of a write
        v = '{1'b1, 1'b1, 2'b10, 2'b10, 32'h0000_0040, 32'h1234_5678, 32'h0, 1'b0, 3};
        access(1, v, "b_seed");
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 2'b10, 2'b10, 32'h0000_0040, 32'h0000_0055);
        @(posedge clk);
        #1;
        sample(1, rd, ab, nw);
        check("b wait1 n_wait", {31'd0, nw}, 32'd0);
        @(posedge clk);
        #1;
        sample(1, rd, ab, nw);
        check("b wait2 n_wait", {31'd0, nw}, 32'd0);
        @(negedge clk);
        n_reset_b = 1'b0;
        @(posedge clk);
        #1;
        sample(1, rd, ab, nw);
        check("b reset n_wait", {31'd0, nw}, 32'd1);
        check("b reset abort", {31'd0, ab}, 32'd0);
        @(negedge clk);
        n_reset_b = 1'b1;
        drive(1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        sample(1, rd, ab, nw);
        check("b idle n_wait", {31'd0, nw}, 32'd1);
        check("b idle abort", {31'd0, ab}, 32'd0);
        v = '{1'b0, 1'b1, 2'b00, 2'b10, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0, 3};
        access(1, v, "b_readback");
        set_idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
